// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//
// Iterative shift-and-add multiplier that borrows the shared execute-stage
// ALU as its adder. It produces the low WIDTH bits of op_a*op_b, which are
// the same for signed and unsigned operands, so no sign handling is needed.
// One multiplier bit is retired per BUSY cycle; with EARLY_EXIT set the
// sequence stops as soon as the remaining multiplier bits are all zero.
//
// Ports
//   clk, rst_n             clock and synchronous active-low reset
//   req_valid/req_ready    request handshake; op_a/op_b held while valid
//   op_a, op_b             multiplicand, multiplier
//   resp_valid/resp_ready  response handshake; result held until accepted
//   result                 low WIDTH bits of the product
//   alu_a, alu_b, alu_ctl  operands and control driven to the shared ALU
//   alu_out                ALU sum, used only while BUSY
// ---------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef ALU_CTL_WIDTH
`define ALU_CTL_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd2
`endif

module alu_mul_seq #(
    parameter int WIDTH      = `WORD_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [WIDTH-1:0]          op_a,
    input  logic [WIDTH-1:0]          op_b,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [WIDTH-1:0]          result,
    output logic [WIDTH-1:0]          alu_a,
    output logic [WIDTH-1:0]          alu_b,
    output logic [`ALU_CTL_WIDTH-1:0] alu_ctl,
    input  logic [WIDTH-1:0]          alu_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and datapath update. In BUSY the ALU sums acc and the
    // shifted multiplicand; the sum is kept only when the current multiplier
    // bit is set. The exit test looks at the already-shifted multiplier so
    // that op_b == 0 still spends exactly one BUSY cycle.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = alu_out;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if ((cnt_q == CNT_LAST) || (EARLY_EXIT && (mplier_d == '0))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs come from the state register; they are also forced
    // low while reset is held so nothing downstream sees a stale response.
    assign req_ready  = rst_n && (state_q == IDLE);
    assign resp_valid = rst_n && (state_q == DONE);
    assign result     = rst_n ? acc_q : '0;

    assign alu_a   = acc_q;
    assign alu_b   = mcand_q;
    assign alu_ctl = `ALU_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef ALU_CTL_WIDTH
`define ALU_CTL_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd2
`endif

module tb_alu_mul_seq;

   // Index 0 drives the EARLY_EXIT=1 instance, index 1 the EARLY_EXIT=0 one.
   logic clk;
   logic rst_n;
   logic reqValid [2];
   logic reqReady [2];
   logic [31:0] opA [2];
   logic [31:0] opB [2];
   logic respValid [2];
   logic respReady [2];
   logic [31:0] result [2];
   logic [31:0] aluA [2];
   logic [31:0] aluB [2];
   logic [`ALU_CTL_WIDTH-1:0] aluCtl [2];
   logic [31:0] aluOut [2];

   int testsRun;
   int failCount;
   bit aluCtlBad;

   alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b1)) dutEarly (
      .clk(clk), .rst_n(rst_n),
      .req_valid(reqValid[0]), .req_ready(reqReady[0]),
      .op_a(opA[0]), .op_b(opB[0]),
      .resp_valid(respValid[0]), .resp_ready(respReady[0]),
      .result(result[0]),
      .alu_a(aluA[0]), .alu_b(aluB[0]), .alu_ctl(aluCtl[0]),
      .alu_out(aluOut[0])
   );

   alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b0)) dutFull (
      .clk(clk), .rst_n(rst_n),
      .req_valid(reqValid[1]), .req_ready(reqReady[1]),
      .op_a(opA[1]), .op_b(opB[1]),
      .resp_valid(respValid[1]), .resp_ready(respReady[1]),
      .result(result[1]),
      .alu_a(aluA[1]), .alu_b(aluB[1]), .alu_ctl(aluCtl[1]),
      .alu_out(aluOut[1])
   );

   // Simple ALU model: adds on ALU_ADD, subtracts otherwise so a wrong
   // control code corrupts the product.
   assign aluOut[0] = (aluCtl[0] == `ALU_ADD) ? aluA[0] + aluB[0] : aluA[0] - aluB[0];
   assign aluOut[1] = (aluCtl[1] == `ALU_ADD) ? aluA[1] + aluB[1] : aluA[1] - aluB[1];

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Busy cycles expected with early exit: position of the highest set bit
   // of the multiplier plus one, and at least one cycle.
   function automatic int busyEarly(input logic [31:0] b);
      int n;
      n = 1;
      for (int i = 0; i < 32; i++) begin
         if (b[i]) n = i + 1;
      end
      return n;
   endfunction

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one request and waits for the response without accepting it.
   // edges counts clock edges from the accept edge (inclusive) up to the
   // edge that raises resp_valid.
   task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int edges);
      int guard;
      @(negedge clk);
      reqValid[sel] = 1'b1;
      opA[sel] = a;
      opB[sel] = b;
      respReady[sel] = 1'b0;
      guard = 0;
      while (reqReady[sel] !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) checkOutput("acceptTimeout", 64'd0, 64'd1);
      @(negedge clk);
      reqValid[sel] = 1'b0;
      edges = 1;
      guard = 0;
      while (respValid[sel] !== 1'b1 && guard < 200) begin
         if (aluCtl[sel] !== `ALU_ADD) aluCtlBad = 1'b1;
         @(negedge clk);
         edges++;
         guard++;
      end
      if (guard >= 200) checkOutput("respTimeout", 64'd0, 64'd1);
      res = result[sel];
   endtask

   // Accepts the pending response with a one-cycle resp_ready pulse.
   task automatic completeResp(input int sel);
      @(negedge clk);
      respReady[sel] = 1'b1;
      @(negedge clk);
      respReady[sel] = 1'b0;
   endtask

   // Directed sequence followed by a short random regression on both instances.
   initial begin
      logic [31:0] res;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] prod;
      int edges;
      int expEdges;

      testsRun = 0;
      failCount = 0;
      aluCtlBad = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         reqValid[i] = 1'b0;
         opA[i] = '0;
         opB[i] = '0;
         respReady[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      checkOutput("resetReqReady", 64'(reqReady[0]), 64'd0);
      checkOutput("resetRespValid", 64'(respValid[0]), 64'd0);
      checkOutput("resetResult", 64'(result[0]), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idleReqReady", 64'(reqReady[0]), 64'd1);
      checkOutput("idleAluCtl", 64'(aluCtl[0]), 64'(`ALU_ADD));

      // 7*6 with early exit: 3 busy cycles.
      applyStimulus(0, 32'd7, 32'd6, res, edges);
      checkOutput("mul7x6", 64'(res), 64'd42);
      checkOutput("lat7x6", 64'(edges), 64'd4);
      completeResp(0);
      checkOutput("idleAfter7x6", 64'(reqReady[0]), 64'd1);

      // All-ones operands run the full width.
      aluCtlBad = 1'b0;
      applyStimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, edges);
      checkOutput("mulOnes", 64'(res), 64'h1);
      checkOutput("latOnes", 64'(edges), 64'd33);
      checkOutput("aluCtlBusy", 64'(aluCtlBad), 64'd0);
      completeResp(0);

      // Zero multiplier exits after one busy cycle; MSB-only multiplier runs 32.
      applyStimulus(0, 32'h1234_5678, 32'h0, res, edges);
      checkOutput("mulZero", 64'(res), 64'd0);
      checkOutput("latZero", 64'(edges), 64'd2);
      completeResp(0);
      applyStimulus(0, 32'd3, 32'h8000_0000, res, edges);
      checkOutput("mulMsb", 64'(res), 64'h8000_0000);
      checkOutput("latMsb", 64'(edges), 64'd33);
      completeResp(0);

      // Backpressure: response held for 5 cycles, a request pulse is ignored.
      applyStimulus(0, 32'd100, 32'd200, res, edges);
      checkOutput("mulBp", 64'(res), 64'd20000);
      checkOutput("latBp", 64'(edges), 64'd9);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("bpRespValid", 64'(respValid[0]), 64'd1);
         checkOutput("bpResult", 64'(result[0]), 64'd20000);
         checkOutput("bpReqReady", 64'(reqReady[0]), 64'd0);
         reqValid[0] = (i == 2);
         opA[0] = 32'd9;
         opB[0] = 32'd9;
      end
      reqValid[0] = 1'b0;
      completeResp(0);
      checkOutput("bpIdle", 64'(reqReady[0]), 64'd1);
      @(negedge clk);
      checkOutput("bpStillIdle", 64'(reqReady[0]), 64'd1);
      checkOutput("bpNoResp", 64'(respValid[0]), 64'd0);

      // Reset in the tenth busy cycle drops the operation.
      @(negedge clk);
      reqValid[0] = 1'b1;
      opA[0] = 32'hFFFF_FFFF;
      opB[0] = 32'hFFFF_FFFF;
      @(negedge clk);
      reqValid[0] = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midRstRespValid", 64'(respValid[0]), 64'd0);
      checkOutput("midRstReqReady", 64'(reqReady[0]), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("postRstIdle", 64'(reqReady[0]), 64'd1);
      checkOutput("postRstNoResp", 64'(respValid[0]), 64'd0);
      applyStimulus(0, 32'd5, 32'd5, res, edges);
      checkOutput("mul5x5", 64'(res), 64'd25);
      checkOutput("lat5x5", 64'(edges), 64'd4);
      completeResp(0);

      // Full-length instance always spends 32 busy cycles.
      applyStimulus(1, 32'd7, 32'd6, res, edges);
      checkOutput("fullMul7x6", 64'(res), 64'd42);
      checkOutput("fullLat7x6", 64'(edges), 64'd33);
      completeResp(1);
      applyStimulus(1, 32'hDEAD_BEEF, 32'h0, res, edges);
      checkOutput("fullMulZero", 64'(res), 64'd0);
      checkOutput("fullLatZero", 64'(edges), 64'd33);
      completeResp(1);

      // Random regression on both instances.
      for (int sel = 0; sel < 2; sel++) begin
         for (int n = 0; n < 150; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            prod = a * b;
            expEdges = (sel == 0) ? busyEarly(b) + 1 : 33;
            applyStimulus(sel, a, b, res, edges);
            checkOutput("randMul", 64'(res), 64'(prod));
            checkOutput("randLat", 64'(edges), 64'(expEdges));
            completeResp(sel);
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
